multi_rate_tick_gen: RTL
========================

Name: multi_rate_tick_gen

Overview:
- Parametrised, multi-channel successor to the single-output divider. Each channel has its own period register, run mode, single-cycle tick output and 50%-duty toggle output.
- Sits between the board clock and the game-of-life engine / display refresh logic. Supplies generation-step ticks, blink rates and one-shot delays from one block.
- Periods are loaded through a strobe and applied glitch-free at the channel's wrap point.

Parameters:
- CHANNELS, 4, number of independent tick channels (1..16).
- CNT_W, 31, counter and period width in bits.
- DEFAULT_PERIOD, 50_000_000, period value loaded into every channel at reset.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  CHANNELS  per-channel run enable, level.
- mode  input  2*CHANNELS  per-channel mode, channel i uses bits [2i+1:2i].
- period  input  CNT_W*CHANNELS  per-channel period value, channel i uses bits [CNT_W*i +: CNT_W].
- load  input  CHANNELS  per-channel one-cycle strobe that captures period.
- restart  input  CHANNELS  per-channel one-cycle strobe: clear counter and arm the channel.
- tick  output  CHANNELS  one-cycle pulse at each terminal count.
- clk_out  output  CHANNELS  toggles at each terminal count.
- busy  output  CHANNELS  channel is actively counting.

Behaviour:
- Per-channel state: cnt[CNT_W], active period prd[CNT_W], pending period pend[CNT_W], pend_vld, armed, clk_out, tick. All outputs are registered.
- Reset (rst_n low, asynchronous): cnt=0, prd=DEFAULT_PERIOD, pend_vld=0, armed=0, tick=0, clk_out=0, busy=0.
- Terminal condition: en & counting & (cnt >= prd).
  - On terminal: cnt<=0, tick<=1 for exactly one cycle, clk_out<=~clk_out.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - Tick spacing is prd+1 cycles; clk_out period is 2*(prd+1) cycles.
  - prd=0 gives tick every cycle and clk_out toggling every cycle.
- Modes:
  - 00 FREE: counts whenever en=1; busy=en.
  - 01 ONESHOT: counts only while armed. restart sets armed=1. On the first terminal: tick, toggle, then armed=0 and cnt held at 0. busy=armed&en.
  - 10 HOLD: cnt, clk_out and armed frozen; tick=0; busy=0.
  - 11: reserved, decoded as FREE.
- en=0: cnt and clk_out hold, tick=0. Re-enabling resumes from the held cnt.
- load strobe: pend<=period slice, pend_vld<=1. The pending value is applied (prd<=pend, pend_vld<=0) only at the next terminal, or immediately if the channel is not counting (en=0, HOLD, or idle ONESHOT).
- load coincident with terminal: the new period slice goes directly into prd at that wrap; pend_vld=0.
- Multiple loads before a wrap: last one wins.
- restart: cnt<=0, clk_out<=0, tick<=0 that cycle, armed<=1. A pending period is applied immediately.
- restart and load in the same cycle: prd<=period slice immediately, cnt<=0.
- restart has priority over terminal in the same cycle.
- Period reduced below the current cnt: the >= compare forces a wrap on the next counting cycle. No 2^CNT_W-cycle overrun.
- Channels are fully independent. No cross-channel priority.
- Reset asserted mid-count returns all channels to reset values asynchronously. Outputs are low on the first cycle after deassertion.

Decomposition:
- Shared package/header holds:
  - MODE_FREE=2'b00, MODE_ONESHOT=2'b01, MODE_HOLD=2'b10, MODE_RSVD=2'b11.
  - The default CNT_W.
- One sub-module, tick_channel (params CNT_W, DEFAULT_PERIOD), implements one channel.
- The top level generate-instantiates tick_channel CHANNELS times and only slices buses.

Test Plan:
- Reset, then ch0 FREE en=1, load period=3 → after the load cycle, tick every 4 cycles; clk_out period 8 cycles; busy=1.
- ch1 period=9 running, load period=2 when cnt=5 → next tick at cnt=9 (old period), then ticks every 3 cycles.
- ch2 ONESHOT period=4, restart pulse → busy high for 5 cycles, single tick, clk_out toggles once, then busy=0 and no further ticks.
- ch3 FREE period=0 → tick constantly 1 and clk_out alternating every cycle. Switch to HOLD → tick=0 and clk_out frozen. Back to FREE → resumes.
- ch0 period=20 at cnt=15, load period=5 with en=0, then en=1 → immediate apply; wrap on the first enabled cycle (cnt>=prd); subsequent spacing 6 cycles.
- Assert rst_n low mid-count on all channels → tick, clk_out and busy clear without a clock edge. After release, each channel counts from 0 with DEFAULT_PERIOD.

Source files
------------

// File: rtl/multi_rate_tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator: channel modes and
// default widths/periods.
package multi_rate_tick_gen_pkg;

  localparam int          CNT_W_DEF          = 31;
  localparam int unsigned DEFAULT_PERIOD_DEF = 50_000_000;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_ONESHOT = 2'b01,
    MODE_HOLD    = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // Whether a channel in mode m advances its counter; the reserved code runs as FREE.
  function automatic logic mode_counts(input mode_e m, input logic armed);
    case (m)
      MODE_ONESHOT: return armed;
      MODE_HOLD:    return 1'b0;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/multi_rate_tick_gen_if.sv
// Control/status bundle of the tick generator; the controller holds the master
// side, the generator the slave side.
interface multi_rate_tick_gen_if
  import multi_rate_tick_gen_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = CNT_W_DEF
);
  logic [CHANNELS-1:0]       en;
  logic [2*CHANNELS-1:0]     mode;
  logic [CNT_W*CHANNELS-1:0] period;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS-1:0]       restart;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       clk_out;
  logic [CHANNELS-1:0]       busy;

  modport master (
    output en, mode, period, load, restart,
    input  tick, clk_out, busy
  );

  modport slave (
    input  en, mode, period, load, restart,
    output tick, clk_out, busy
  );
endinterface

// File: rtl/multi_rate_tick_gen_tick_channel.sv
// One tick channel: wrap counter with glitch-free period update, one-shot arming,
// single-cycle tick and 50%-duty toggle output.
module tick_channel
  import multi_rate_tick_gen_pkg::*;
#(
  parameter int          CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             load_i,
  input  logic             restart_i,
  output logic             tick_o,
  output logic             clk_out_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] RST_PRD = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] prd_q, prd_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             armed_q, armed_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;

  mode_e mode;
  logic  run;
  logic  term;

  assign mode = mode_e'(mode_i);
  assign run  = en_i & mode_counts(mode, armed_q);
  // >= rather than == so a period shrunk below cnt wraps at once instead of overrunning.
  assign term = run & (cnt_q >= prd_q);

  always_comb begin
    cnt_d      = cnt_q;
    prd_d      = prd_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    armed_d    = armed_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;

    if (restart_i) begin
      cnt_d      = '0;
      clk_out_d  = 1'b0;
      armed_d    = 1'b1;
      pend_vld_d = 1'b0;
      if (load_i) begin
        prd_d = period_i;
      end else if (pend_vld_q) begin
        prd_d = pend_q;
      end
    end else begin
      if (term) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
        if (mode == MODE_ONESHOT) begin
          armed_d = 1'b0;
        end
      end else if (run) begin
        cnt_d = cnt_q + 1'b1;
      end

      // A new period only takes effect at a wrap, or straight away when the counter is parked.
      if (load_i) begin
        if (term || !run) begin
          prd_d      = period_i;
          pend_vld_d = 1'b0;
        end else begin
          pend_d     = period_i;
          pend_vld_d = 1'b1;
        end
      end else if (pend_vld_q && (term || !run)) begin
        prd_d      = pend_q;
        pend_vld_d = 1'b0;
      end
    end

    busy_d = en_i & mode_counts(mode, armed_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      prd_q      <= RST_PRD;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      armed_q    <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      prd_q      <= prd_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      armed_q    <= armed_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;
  assign busy_o    = busy_q;

endmodule

// File: rtl/multi_rate_tick_gen.sv
// Multi-channel tick generator: CHANNELS independent tick_channel instances,
// the top only slices the packed buses.
module multi_rate_tick_gen
  import multi_rate_tick_gen_pkg::*;
#(
  parameter int          CHANNELS       = 4,
  parameter int          CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multi_rate_tick_gen_if.slave bus
);

  logic [CHANNELS-1:0] tick_w;
  logic [CHANNELS-1:0] clk_out_w;
  logic [CHANNELS-1:0] busy_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tick_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (bus.en[i]),
      .mode_i    (bus.mode[2*i +: 2]),
      .period_i  (bus.period[CNT_W*i +: CNT_W]),
      .load_i    (bus.load[i]),
      .restart_i (bus.restart[i]),
      .tick_o    (tick_w[i]),
      .clk_out_o (clk_out_w[i]),
      .busy_o    (busy_w[i])
    );
  end

  assign bus.tick    = tick_w;
  assign bus.clk_out = clk_out_w;
  assign bus.busy    = busy_w;

endmodule
